// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq -- EX-stage execute unit: single-cycle base ALU plus iterative
// RV32M multiply (radix-2 shift-add) and divide (restoring).
//
// Ports:
//   clk, rst_n            clock / asynchronous active-low reset
//   in_valid, in_ready    request handshake (in_ready only while IDLE)
//   kill                  abort an in-flight iterative op
//   A, B                  operands
//   ALUControl, funct3,   base op select / variant; funct3 selects the M op
//   funct7_5, m_op        when m_op=1
//   out_valid             one-cycle pulse with Result/Zero
//   Result, Zero          registered result and Result==0 flag
//   busy                  iterative op in progress
//
// Optional build macro ALU_MDU_EARLY_OUT_EN: trivial M ops (divide by zero,
// signed overflow, zero multiply operand, zero dividend) finish in one cycle
// and division skips the leading zero bits of the dividend magnitude.
module alu_mdu_seq #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            kill,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [2:0]      ALUControl,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic            m_op,
    output logic            out_valid,
    output logic [XLEN-1:0] Result,
    output logic            Zero,
    output logic            busy
);
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t              state;
    logic [2*XLEN-1:0]   acc, mcand;
    logic [XLEN-1:0]     mplier;   // multiplier in MUL, dividend/quotient in DIV
    logic [XLEN-1:0]     rem, dvsr;
    logic [SHW-1:0]      cnt;
    logic [1:0]          f3;
    logic                neg_q, neg_r;

    logic accept;
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign accept   = in_valid & in_ready;

    // ---------------- base ALU ----------------
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;
    assign shamt = B[SHW-1:0];
    always_comb begin
        alu_res = '0;
        case (ALUControl)
            3'd0: alu_res = A + B;
            3'd1: alu_res = A + ~B + 1'b1;
            3'd2: alu_res = A & B;
            3'd3: alu_res = A | B;
            3'd4: alu_res = A ^ B;
            3'd5: alu_res = funct3[0] ? {{(XLEN-1){1'b0}}, (A < B)}
                                      : {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
            default:
                if (!funct3[2])    alu_res = A << shamt;
                else if (funct7_5) alu_res = $unsigned($signed(A) >>> shamt);
                else               alu_res = A >> shamt;
        endcase
    end

    // ---------------- operand conditioning at accept ----------------
    // Signed operands: A for MULH/MULHSU/DIV/REM, B for MULH/DIV/REM.
    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    assign a_signed = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
    assign b_signed = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    assign a_neg    = a_signed & A[XLEN-1];
    assign b_neg    = b_signed & B[XLEN-1];
    assign a_mag    = a_neg ? -A : A;
    assign b_mag    = b_neg ? -B : B;

    // ---------------- iteration datapath ----------------
    logic [2*XLEN-1:0] mul_acc_nxt, prod;
    logic [XLEN-1:0]   mul_res;
    assign mul_acc_nxt = acc + (mplier[0] ? mcand : '0);
    assign prod        = neg_q ? -mul_acc_nxt : mul_acc_nxt;
    assign mul_res     = (f3 == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    // Remainder stays below the divisor, so an XLEN+1 bit trial subtract is
    // enough; the borrow bit decides the quotient bit.
    logic [XLEN:0]   r_sh, diff;
    logic            ge;
    logic [XLEN-1:0] rem_nxt, quo_nxt, div_res;
    assign r_sh    = {rem, mplier[XLEN-1]};
    assign diff    = r_sh - {1'b0, dvsr};
    assign ge      = ~diff[XLEN];
    assign rem_nxt = ge ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
    assign quo_nxt = {mplier[XLEN-2:0], ge};
    assign div_res = f3[1] ? (neg_r ? -rem_nxt : rem_nxt)
                           : (neg_q ? -quo_nxt : quo_nxt);

    logic last;
    assign last = (cnt == SHW'(XLEN-1));

`ifdef ALU_MDU_EARLY_OUT_EN
    function automatic logic [SHW-1:0] clz(input logic [XLEN-1:0] v);
        clz = '0;
        for (int i = 0; i < XLEN; i++)
            if (v[i]) clz = SHW'(XLEN-1-i);
    endfunction

    logic            is_div, dz, ovf, early_hit;
    logic [XLEN-1:0] early_res;
    assign is_div    = funct3[2];
    assign dz        = is_div & (B == '0);
    assign ovf       = is_div & ~funct3[0] & (A == {1'b1, {(XLEN-1){1'b0}}}) & (B == '1);
    assign early_hit = dz | ovf | (A == '0) | (~is_div & (B == '0));
    always_comb begin
        early_res = '0;
        if (dz)       early_res = funct3[1] ? A : '1;
        else if (ovf) early_res = funct3[1] ? '0 : A;
    end
`endif

    // ---------------- control / state ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            Result    <= '0;
            Zero      <= 1'b1;
            out_valid <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            rem       <= '0;
            dvsr      <= '0;
            cnt       <= '0;
            f3        <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (!m_op) begin
                        Result    <= alu_res;
                        Zero      <= (alu_res == '0);
                        out_valid <= 1'b1;
                    end else begin
                        f3  <= funct3[1:0];
                        cnt <= '0;
`ifdef ALU_MDU_EARLY_OUT_EN
                        if (early_hit) begin
                            Result    <= early_res;
                            Zero      <= (early_res == '0);
                            out_valid <= 1'b1;
                        end else
`endif
                        if (!funct3[2]) begin
                            acc    <= '0;
                            mcand  <= {{XLEN{1'b0}}, a_mag};
                            mplier <= b_mag;
                            neg_q  <= a_neg ^ b_neg;
                            state  <= MUL;
                        end else begin
                            rem    <= '0;
                            dvsr   <= b_mag;
                            // Quotient of a divide by zero is all ones regardless of sign.
                            neg_q  <= (a_neg ^ b_neg) & (B != '0);
                            neg_r  <= a_neg;
                            state  <= DIV;
`ifdef ALU_MDU_EARLY_OUT_EN
                            mplier <= a_mag << clz(a_mag);
                            cnt    <= clz(a_mag);
`else
                            mplier <= a_mag;
`endif
                        end
                    end
                end
                MUL: if (kill) state <= IDLE;
                else begin
                    acc    <= mul_acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        Result    <= mul_res;
                        Zero      <= (mul_res == '0);
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                DIV: if (kill) state <= IDLE;
                else begin
                    rem    <= rem_nxt;
                    mplier <= quo_nxt;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        Result    <= div_res;
                        Zero      <= (div_res == '0);
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed self-checking bench for alu_mdu_seq (XLEN=32).
module tb_alu_mdu_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        kill = 1'b0;
    logic [31:0] A = '0, B = '0;
    logic [2:0]  ALUControl = '0, funct3 = '0;
    logic        funct7_5 = 1'b0, m_op = 1'b0;
    logic        out_valid, Zero, busy;
    logic [31:0] Result;

    int checks = 0;
    int errors = 0;

`ifdef ALU_MDU_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif

    alu_mdu_seq #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .kill(kill), .A(A), .B(B), .ALUControl(ALUControl), .funct3(funct3),
        .funct7_5(funct7_5), .m_op(m_op), .out_valid(out_valid),
        .Result(Result), .Zero(Zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Latency of a non-trivial divide given the dividend magnitude.
    function automatic int div_lat(input logic [31:0] amag);
        int sig = 0;
        for (int i = 0; i < 32; i++) if (amag[i]) sig = i + 1;
        return EO ? 1 + sig : 33;
    endfunction

    task automatic drive(input logic [2:0] alu, input logic [2:0] f3, input logic f75,
                         input logic mop, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1; ALUControl = alu; funct3 = f3; funct7_5 = f75; m_op = mop; A = a; B = b;
    endtask

    // Base op: accept at next edge, result one cycle later.
    task automatic base(input string tag, input logic [2:0] alu, input logic [2:0] f3,
                        input logic f75, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
        drive(alu, f3, f75, 1'b0, a, b);
        @(posedge clk); #1;
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk(tag, Result, exp);
        chk({tag, "_zero"}, 32'(Zero), 32'(exp == 32'd0));
    endtask

    // M op: measure latency and busy cycles, bounded wait.
    task automatic mop(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
        int n, bc;
        @(negedge clk);
        drive(3'd0, f3, 1'b0, 1'b1, a, b);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1; bc = 0;
        while (!out_valid && n < 100) begin
            if (busy) bc++;
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        chk({tag, "_busy"}, 32'(bc), 32'(lat - 1));
        chk(tag, Result, exp);
    endtask

    initial begin
        int ov;
        logic [31:0] saved;
        // reset state
        #12;
        chk("rst_result", Result, 32'd0);
        chk("rst_zero", 32'(Zero), 32'd1);
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk); rst_n = 1'b1;

        // base ops back to back
        @(negedge clk);
        base("add", 3'd0, 3'd0, 1'b0, 32'd7, 32'd5, 32'd12);
        base("sub", 3'd1, 3'd0, 1'b0, 32'd3, 32'd5, 32'hFFFF_FFFE);
        base("slt", 3'd5, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1);
        base("sltu", 3'd5, 3'd3, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0);
        base("sra", 3'd6, 3'd5, 1'b1, 32'h8000_0000, 32'd4, 32'hF800_0000);
        base("srl", 3'd7, 3'd5, 1'b0, 32'h8000_0000, 32'd4, 32'h0800_0000);
        base("sll", 3'd6, 3'd1, 1'b0, 32'h0000_0003, 32'd31, 32'h8000_0000);
        base("sub0", 3'd1, 3'd0, 1'b0, 32'd5, 32'd5, 32'd0);
        base("xor", 3'd4, 3'd0, 1'b0, 32'hF0F0_1234, 32'h0FF0_1234, 32'hFF00_0000);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("base_pulse", 32'(out_valid), 32'd0);

        // multiply
        mop("mulh",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        mop("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        mop("mul",    3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
        mop("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        mop("mul_big", 3'd0, 32'd12345, 32'd6789, 32'd83810205, 33);
        mop("mul_z",  3'd0, 32'd0, 32'd5, 32'd0, EO ? 1 : 33);

        // divide / remainder signs
        mop("div",  3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, div_lat(32'd7));
        mop("rem",  3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, div_lat(32'd7));
        mop("divu", 3'd5, 32'd100, 32'd7, 32'd14, div_lat(32'd100));
        mop("remu", 3'd7, 32'd100, 32'd7, 32'd2, div_lat(32'd100));

        // corner cases
        mop("div0",   3'd4, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, EO ? 1 : 33);
        mop("divn0",  3'd4, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, EO ? 1 : 33);
        mop("rem0",   3'd6, 32'h1234_5678, 32'd0, 32'h1234_5678, EO ? 1 : 33);
        mop("divu0",  3'd5, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, EO ? 1 : 33);
        mop("remu0",  3'd7, 32'h8765_4321, 32'd0, 32'h8765_4321, EO ? 1 : 33);
        mop("div_ov", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, EO ? 1 : 33);
        mop("rem_ov", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, EO ? 1 : 33);

        // kill at cycle 10 of a DIV
        saved = Result;
        @(negedge clk);
        drive(3'd0, 3'd5, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'd3);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        chk("kill_busy", 32'(busy), 32'd1);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill_ready", 32'(in_ready), 32'd1);
        chk("kill_vld", 32'(out_valid), 32'd0);
        chk("kill_res", Result, saved);
        base("add_after_kill", 3'd0, 3'd0, 1'b0, 32'd1, 32'd1, 32'd2);
        in_valid = 1'b0;
        ov = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) ov++; end
        chk("kill_no_late_vld", 32'(ov), 32'd0);

        // asynchronous reset mid-MUL
        @(negedge clk);
        drive(3'd0, 3'd0, 1'b0, 1'b1, 32'd3, 32'd5);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_res", Result, 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_vld", 32'(out_valid), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        ov = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) ov++; end
        chk("arst_no_vld", 32'(ov), 32'd0);
        @(negedge clk);
        base("add_after_rst", 3'd0, 3'd0, 1'b0, 32'd20, 32'd22, 32'd42);
        in_valid = 1'b0;
        mop("mul_after_rst", 3'd0, 32'd3, 32'd5, 32'd15, 33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
